// File: rtl/nec_ir_pkg.sv
// Shared constants for the NEC IR frame decoder: FSM state codes, pulse-width
// windows in microseconds, and bit offsets of the fields inside a 32-bit frame.
package nec_ir_pkg;

  // Decoder FSM state encoding
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP_MARK  = 3'd5;
  localparam logic [2:0] S_RPT_MARK   = 3'd6;

  // Width of every microsecond counter; the edge-interval counter saturates at all-ones
  localparam int unsigned     US_W   = 17;
  localparam logic [US_W-1:0] US_MAX = '1;

  // Acceptance windows (inclusive), judged at the edge that ends each duration
  localparam logic [US_W-1:0] LEAD_MARK_MIN  = 17'd8000;
  localparam logic [US_W-1:0] LEAD_MARK_MAX  = 17'd10000;
  localparam logic [US_W-1:0] DATA_SPACE_MIN = 17'd3500;
  localparam logic [US_W-1:0] DATA_SPACE_MAX = 17'd5500;
  localparam logic [US_W-1:0] RPT_SPACE_MIN  = 17'd1750;
  localparam logic [US_W-1:0] RPT_SPACE_MAX  = 17'd2750;
  localparam logic [US_W-1:0] BIT_MARK_MIN   = 17'd300;
  localparam logic [US_W-1:0] BIT_MARK_MAX   = 17'd900;
  localparam logic [US_W-1:0] BIT0_SPACE_MIN = 17'd300;
  localparam logic [US_W-1:0] BIT0_SPACE_MAX = 17'd900;
  localparam logic [US_W-1:0] BIT1_SPACE_MIN = 17'd1300;
  localparam logic [US_W-1:0] BIT1_SPACE_MAX = 17'd2100;

  // Field offsets inside the frame {~cmd, cmd, ~addr, addr}
  localparam int unsigned ADDR_LSB     = 0;
  localparam int unsigned ADDR_INV_LSB = 8;
  localparam int unsigned CMD_LSB      = 16;
  localparam int unsigned CMD_INV_LSB  = 24;

  function automatic logic in_window(input logic [US_W-1:0] t,
                                     input logic [US_W-1:0] lo,
                                     input logic [US_W-1:0] hi);
    return (t >= lo) && (t <= hi);
  endfunction

endpackage

// File: rtl/ir_input_conditioner.sv
// Front end for the raw IR receiver pin: two-stage synchronizer, edge detector
// and the clock prescaler that produces the 1 us timebase tick.
module ir_input_conditioner #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_data,
  output logic o_fall,
  output logic o_rise,
  output logic o_us_tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [DIV_W-1:0] r_div;

  // Synchronize the asynchronous pin and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the chain resets to the idle-high line level so leaving reset never fakes a fall.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_data;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Free-running divider, wraps every TICK_DIV clocks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == DIV_W'(TICK_DIV - 1)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_fall    = r_prev & ~r_sync2;
  assign o_rise    = ~r_prev & r_sync2;
  assign o_us_tick = (r_div == DIV_W'(TICK_DIV - 1));

endmodule

// File: rtl/nec_ir_frame_decoder.sv
// NEC IR receive decoder: measures mark/space durations of the demodulated
// receiver output, assembles 32-bit frames LSB-first, checks the inverse
// fields and recognises repeat codes shortly after a valid frame.
module nec_ir_frame_decoder
  import nec_ir_pkg::*;
#(
  parameter int TICK_DIV      = 50,
  parameter bit STRICT_ADDR   = 1'b1,
  parameter int TIMEOUT_US    = 12000,
  parameter int RPT_WINDOW_US = 120000,
  // Microseconds credited per timebase tick; 1 on hardware, larger values compress time
  parameter int US_PER_TICK   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        repeat_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [US_W-1:0] STEP      = US_W'(US_PER_TICK);
  localparam logic [US_W-1:0] TIMEOUT_L = US_W'(TIMEOUT_US);
  localparam logic [US_W-1:0] WINDOW_L  = US_W'(RPT_WINDOW_US);

  logic            w_fall;
  logic            w_rise;
  logic            w_tick;
  logic            w_edge;
  logic            w_timeout;
  logic            w_mark_ok;
  logic            w_inv_ok;
  logic            w_frame_ok;

  logic [2:0]      r_state;
  logic [US_W-1:0] r_us_cnt;
  logic [US_W-1:0] r_win_cnt;
  logic            r_have_frame;
  logic [4:0]      r_bitcnt;
  logic [31:0]     r_sr;
  logic [31:0]     r_data_out;
  logic            r_data_ready;
  logic            r_repeat_valid;
  logic            r_frame_err;

  ir_input_conditioner #(.TICK_DIV(TICK_DIV)) u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (data_in),
    .o_fall    (w_fall),
    .o_rise    (w_rise),
    .o_us_tick (w_tick)
  );

  assign w_edge     = w_fall | w_rise;
  assign w_timeout  = (r_us_cnt > TIMEOUT_L);
  assign w_mark_ok  = in_window(r_us_cnt, BIT_MARK_MIN, BIT_MARK_MAX);
  assign w_inv_ok   = (r_sr[CMD_INV_LSB +: 8] == ~r_sr[CMD_LSB +: 8]) &&
                      (!STRICT_ADDR || (r_sr[ADDR_INV_LSB +: 8] == ~r_sr[ADDR_LSB +: 8]));
  assign w_frame_ok = (r_state == S_STOP_MARK) && w_rise && w_mark_ok && w_inv_ok;

  // Time since the last line edge, saturating so long idle periods never wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_us_cnt <= '0;
    end else if (w_edge) begin
      r_us_cnt <= '0;
    end else if (w_tick) begin
      r_us_cnt <= (r_us_cnt > US_MAX - STEP) ? US_MAX : r_us_cnt + STEP;
    end
  end

  // Repeat window: armed by each valid frame, disarmed once the window has elapsed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_have_frame <= 1'b0;
      r_win_cnt    <= '0;
    end else if (w_frame_ok) begin
      r_have_frame <= 1'b1;
      r_win_cnt    <= '0;
    end else if (r_have_frame && w_tick) begin
      if (r_win_cnt >= WINDOW_L - STEP) begin
        r_have_frame <= 1'b0;
      end else begin
        r_win_cnt <= r_win_cnt + STEP;
      end
    end
  end

  // Frame FSM with bit assembly and registered result pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_bitcnt       <= '0;
      r_sr           <= '0;
      r_data_out     <= '0;
      r_data_ready   <= 1'b0;
      r_repeat_valid <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so any set below lasts exactly one clock.
      r_data_ready   <= 1'b0;
      r_repeat_valid <= 1'b0;
      r_frame_err    <= 1'b0;
      // An edge arriving in the same cycle as the timeout is still decoded
      if ((r_state != S_IDLE) && !w_edge && w_timeout) begin
        r_frame_err <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fall) r_state <= S_LEAD_MARK;
          end
          S_LEAD_MARK: begin
            if (w_rise) begin
              if (in_window(r_us_cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                r_state <= S_LEAD_SPACE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end
            end
          end
          S_LEAD_SPACE: begin
            if (w_fall) begin
              if (in_window(r_us_cnt, DATA_SPACE_MIN, DATA_SPACE_MAX)) begin
                r_bitcnt <= '0;
                r_state  <= S_BIT_MARK;
              end else if (in_window(r_us_cnt, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                r_state <= S_RPT_MARK;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end
            end
          end
          S_BIT_MARK: begin
            if (w_rise) begin
              if (w_mark_ok) begin
                r_state <= S_BIT_SPACE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end
            end
          end
          S_BIT_SPACE: begin
            if (w_fall) begin
              if (in_window(r_us_cnt, BIT0_SPACE_MIN, BIT0_SPACE_MAX) ||
                  in_window(r_us_cnt, BIT1_SPACE_MIN, BIT1_SPACE_MAX)) begin
                r_sr     <= {in_window(r_us_cnt, BIT1_SPACE_MIN, BIT1_SPACE_MAX), r_sr[31:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
                r_state  <= (r_bitcnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end
            end
          end
          S_STOP_MARK: begin
            if (w_rise) begin
              if (w_frame_ok) begin
                r_data_out   <= r_sr;
                r_data_ready <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= S_IDLE;
            end
          end
          S_RPT_MARK: begin
            if (w_rise) begin
              if (w_mark_ok) begin
                r_repeat_valid <= r_have_frame;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out     = r_data_out;
  assign data_ready   = r_data_ready;
  assign repeat_valid = r_repeat_valid;
  assign frame_err    = r_frame_err;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_nec_ir_frame_decoder.sv
// Directed bench for nec_ir_frame_decoder. Time is compressed: one clock is one
// tick and each tick is credited as 50 us, so a nominal NEC frame is ~1350 clocks.
// A second instance with STRICT_ADDR=0 shares the same input line.
module tb_nec_ir_frame_decoder;

  // Nominal NEC durations expressed in 50 us clocks
  localparam int C_LEAD  = 180;  // 9000 us
  localparam int C_DSPC  = 90;   // 4500 us
  localparam int C_RSPC  = 45;   // 2250 us
  localparam int C_MARK  = 11;   // 550 us
  localparam int C_SPC0  = 11;   // 550 us
  localparam int C_SPC1  = 34;   // 1700 us

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b1;
  logic [31:0] data_out, data_out_x;
  logic        data_ready, repeat_valid, frame_err, busy;
  logic        data_ready_x, repeat_valid_x, frame_err_x, busy_x;

  always #5 clk = ~clk;

  nec_ir_frame_decoder #(
    .TICK_DIV(1), .STRICT_ADDR(1'b1), .TIMEOUT_US(12000),
    .RPT_WINDOW_US(120000), .US_PER_TICK(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(data_out),
    .data_ready(data_ready), .repeat_valid(repeat_valid),
    .frame_err(frame_err), .busy(busy)
  );

  nec_ir_frame_decoder #(
    .TICK_DIV(1), .STRICT_ADDR(1'b0), .TIMEOUT_US(12000),
    .RPT_WINDOW_US(120000), .US_PER_TICK(50)
  ) dut_x (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(data_out_x),
    .data_ready(data_ready_x), .repeat_valid(repeat_valid_x),
    .frame_err(frame_err_x), .busy(busy_x)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters sampled on the falling edge
  int   n_dr = 0, n_rv = 0, n_fe = 0, n_drx = 0, n_fex = 0, n_excl = 0, n_wide = 0;
  logic p_dr = 1'b0, p_rv = 1'b0, p_fe = 1'b0;

  always @(negedge clk) begin
    if (data_ready)   n_dr++;
    if (repeat_valid) n_rv++;
    if (frame_err)    n_fe++;
    if (data_ready_x) n_drx++;
    if (frame_err_x)  n_fex++;
    if ((int'(data_ready) + int'(repeat_valid) + int'(frame_err) > 1) ||
        (int'(data_ready_x) + int'(repeat_valid_x) + int'(frame_err_x) > 1)) n_excl++;
    if ((data_ready && p_dr) || (repeat_valid && p_rv) || (frame_err && p_fe)) n_wide++;
    p_dr = data_ready;
    p_rv = repeat_valid;
    p_fe = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive a line level for a number of clocks; always resumes 1 time unit after a posedge
  task automatic hold(input logic lvl, input int cyc);
    data_in = lvl;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leader, 32 data bits LSB-first, and the stop mark left low for the caller to end
  task automatic send_body(input logic [31:0] w);
    hold(1'b0, C_LEAD);
    hold(1'b1, C_DSPC);
    for (int i = 0; i < 32; i++) begin
      hold(1'b0, C_MARK);
      hold(1'b1, w[i] ? C_SPC1 : C_SPC0);
    end
    hold(1'b0, C_MARK);
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_body(w);
    hold(1'b1, 40);
  endtask

  task automatic send_repeat();
    hold(1'b0, C_LEAD);
    hold(1'b1, C_RSPC);
    hold(1'b0, C_MARK);
    hold(1'b1, 40);
  endtask

  initial begin
    int   dr0, rv0, fe0, drx0, fex0, k;
    logic got, busy_before;
    logic [31:0] w6;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_data_ready", 32'(data_ready), 32'h0);
    check("rst_repeat_valid", 32'(repeat_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // 1) addr=0x12 cmd=0x34, pulse exactly 3 clocks after the stop-mark end
    dr0 = n_dr;
    send_body(32'hCB34ED12);
    data_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t1_no_early_pulse", 32'(data_ready), 32'h0);
    @(posedge clk); #1;
    check("t1_pulse_at_3clk", 32'(data_ready), 32'h1);
    check("t1_data_out", data_out, 32'hCB34ED12);
    @(posedge clk); #1;
    check("t1_pulse_width", 32'(data_ready), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_ready_count", n_dr - dr0, 1);
    hold(1'b1, 20);

    // 2) repeat 40 ms after the frame is accepted, one 200 ms later is ignored
    rv0 = n_rv; fe0 = n_fe;
    hold(1'b1, 780);
    send_repeat();
    check("t2_repeat_pulse", n_rv - rv0, 1);
    check("t2_repeat_no_err", n_fe - fe0, 0);
    check("t2_data_kept", data_out, 32'hCB34ED12);
    rv0 = n_rv; fe0 = n_fe; dr0 = n_dr;
    hold(1'b1, 3000);
    send_repeat();
    check("t2_late_no_repeat", n_rv - rv0, 0);
    check("t2_late_no_err", n_fe - fe0, 0);
    check("t2_late_no_ready", n_dr - dr0, 0);

    // 3) bad inverse command fails both, bad inverse address fails only strict
    dr0 = n_dr; fe0 = n_fe; drx0 = n_drx; fex0 = n_fex;
    send_frame(32'h0034ED12);
    check("t3_cmd_inv_err", n_fe - fe0, 1);
    check("t3_cmd_inv_no_ready", n_dr - dr0, 0);
    check("t3_cmd_inv_kept", data_out, 32'hCB34ED12);
    check("t3_ext_cmd_inv_err", n_fex - fex0, 1);
    dr0 = n_dr; fe0 = n_fe; drx0 = n_drx; fex0 = n_fex;
    send_frame(32'hCB340012);
    check("t3_addr_inv_err", n_fe - fe0, 1);
    check("t3_addr_inv_kept", data_out, 32'hCB34ED12);
    check("t3_ext_ready", n_drx - drx0, 1);
    check("t3_ext_no_err", n_fex - fex0, 0);
    check("t3_ext_data_out", data_out_x, 32'hCB340012);

    // 4) 6 ms leader is rejected, following good frame decodes
    fe0 = n_fe; dr0 = n_dr;
    hold(1'b0, 120);
    hold(1'b1, 40);
    check("t4_short_lead_err", n_fe - fe0, 1);
    check("t4_short_lead_idle", 32'(busy), 32'h0);
    send_frame(32'hF00F5AA5);
    check("t4_next_ready", n_dr - dr0, 1);
    check("t4_next_data", data_out, 32'hF00F5AA5);

    // 5) truncated after 10 bits, timeout ~12 ms after the last edge
    fe0 = n_fe;
    hold(1'b0, C_LEAD);
    hold(1'b1, C_DSPC);
    for (int i = 0; i < 9; i++) begin
      hold(1'b0, C_MARK);
      hold(1'b1, C_SPC0);
    end
    hold(1'b0, C_MARK);
    data_in = 1'b1;
    k = 0; got = 1'b0; busy_before = 1'b0;
    while (k < 400 && !got) begin
      busy_before = busy;
      @(posedge clk); #1;
      k++;
      if (frame_err) got = 1'b1;
    end
    check("t5_timeout_seen", 32'(got), 32'h1);
    check("t5_timeout_delay", 32'((k >= 235) && (k <= 255)), 32'h1);
    check("t5_busy_falls", 32'(busy), 32'h0);
    check("t5_busy_before", 32'(busy_before), 32'h1);
    hold(1'b1, 20);
    check("t5_single_err", n_fe - fe0, 1);

    // 6) one-cycle reset during bit 16, then a full frame
    w6 = 32'h00FFFF00;
    hold(1'b0, C_LEAD);
    hold(1'b1, C_DSPC);
    for (int i = 0; i < 16; i++) begin
      hold(1'b0, C_MARK);
      hold(1'b1, w6[i] ? C_SPC1 : C_SPC0);
    end
    hold(1'b0, C_MARK);
    hold(1'b1, 5);
    check("t6_busy_mid_frame", 32'(busy), 32'h1);
    fe0 = n_fe; dr0 = n_dr;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_rst_data_out", data_out, 32'h0);
    check("t6_rst_data_ready", 32'(data_ready), 32'h0);
    check("t6_rst_repeat_valid", 32'(repeat_valid), 32'h0);
    check("t6_rst_frame_err", 32'(frame_err), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    hold(1'b1, 300);
    check("t6_no_err_after_rst", n_fe - fe0, 0);
    send_frame(w6);
    check("t6_ready_after_rst", n_dr - dr0, 1);
    check("t6_data_after_rst", data_out, 32'h00FFFF00);

    // Whole-run pulse properties
    check("excl_pulses", n_excl, 0);
    check("single_cycle_pulses", n_wide, 0);
    check("ext_idle_at_end", 32'(busy_x), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
